// File: rtl/fpmul_arbiter.sv
// Round-robin front end sharing one pipelined FP multiplier between two requesters.
// Operands are issued one cycle after grant; each result is held per requester until rsp_ready.
module fpmul_arbiter #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_x,
    input  logic [63:0] req_y,
    input  logic [5:0]  req_mode,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_z,
    output logic [1:0]  rsp_ovrf,
    output logic [1:0]  rsp_udrf,
    output logic [31:0] fp_X,
    output logic [31:0] fp_Y,
    output logic [2:0]  r_mode,
    input  logic [31:0] fp_Z,
    input  logic        ovrf,
    input  logic        udrf
);

    logic [1:0]         inflight;
    logic [1:0]         elig;
    logic [1:0]         grant;
    logic               ptr_q, ptr_d;
    logic [31:0]        fp_x_q, fp_x_d;
    logic [31:0]        fp_y_q, fp_y_d;
    logic [2:0]         r_mode_q, r_mode_d;
    logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0] tag_id_q, tag_id_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [63:0]        rsp_z_q, rsp_z_d;
    logic [1:0]         rsp_ovrf_q, rsp_ovrf_d;
    logic [1:0]         rsp_udrf_q, rsp_udrf_d;
    logic               cap_vld;
    logic               cap_id;

    always_comb begin
        inflight = 2'b00;
        for (int k = 0; k < MUL_LAT; k++) begin
            if (tag_vld_q[k]) begin
                inflight[tag_id_q[k]] = 1'b1;
            end
        end
    end

    // Eligibility looks only at registered slot state, so a slot freed this
    // cycle cannot be re-granted until the next one.
    always_comb begin
        elig  = req_valid & ~rsp_valid_q & ~inflight & {2{~rst}};
        grant = elig;
        if (elig == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    assign req_ready = grant;

    always_comb begin
        ptr_d    = ptr_q;
        fp_x_d   = fp_x_q;
        fp_y_d   = fp_y_q;
        r_mode_d = r_mode_q;
        if (grant[0]) begin
            ptr_d    = 1'b1;
            fp_x_d   = req_x[31:0];
            fp_y_d   = req_y[31:0];
            r_mode_d = req_mode[2:0];
        end else if (grant[1]) begin
            ptr_d    = 1'b0;
            fp_x_d   = req_x[63:32];
            fp_y_d   = req_y[63:32];
            r_mode_d = req_mode[5:3];
        end
    end

    // Tag stage k is visible k+1 cycles after the grant; the last stage lines
    // up with fp_Z for the operation it describes.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = |grant;
        tag_id_d[0]  = grant[1];
        for (int k = 1; k < MUL_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    assign cap_vld = tag_vld_q[MUL_LAT-1];
    assign cap_id  = tag_id_q[MUL_LAT-1];

    // A requester owns at most one operation, so capture never lands on a full slot.
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_z_d     = rsp_z_q;
        rsp_ovrf_d  = rsp_ovrf_q;
        rsp_udrf_d  = rsp_udrf_q;
        if (cap_vld) begin
            rsp_valid_d[cap_id] = 1'b1;
            rsp_ovrf_d[cap_id]  = ovrf;
            rsp_udrf_d[cap_id]  = udrf;
            if (cap_id) begin
                rsp_z_d[63:32] = fp_Z;
            end else begin
                rsp_z_d[31:0] = fp_Z;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            fp_x_q      <= '0;
            fp_y_q      <= '0;
            r_mode_q    <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_z_q     <= '0;
            rsp_ovrf_q  <= '0;
            rsp_udrf_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            fp_x_q      <= fp_x_d;
            fp_y_q      <= fp_y_d;
            r_mode_q    <= r_mode_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_ovrf_q  <= rsp_ovrf_d;
            rsp_udrf_q  <= rsp_udrf_d;
        end
    end

    assign fp_X      = fp_x_q;
    assign fp_Y      = fp_y_q;
    assign r_mode    = r_mode_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_ovrf  = rsp_ovrf_q;
    assign rsp_udrf  = rsp_udrf_q;

endmodule
